// File: rtl/branch_resolve_unit_if.sv
// Bus bundle for branch_resolve_unit: decode-stage inputs, control strobes,
// registered resolution results and event counters.
interface branch_resolve_unit_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
);
    logic             in_valid;
    logic             stall;
    logic             flush;
    logic             cnt_clr;
    logic [5:0]       opcode;
    logic [4:0]       rt;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [WIDTH-1:0] pc_plus4;
    logic [15:0]      imm;
    logic [25:0]      jidx;
    logic             pred_taken;

    logic             out_valid;
    logic             is_ctrl;
    logic             taken;
    logic [WIDTH-1:0] target;
    logic             redirect;
    logic [WIDTH-1:0] redirect_pc;
    logic [CNT_W-1:0] cnt_ctrl;
    logic [CNT_W-1:0] cnt_taken;
    logic [CNT_W-1:0] cnt_mispred;

    modport master (
        output in_valid, stall, flush, cnt_clr, opcode, rt, rd1, rd2,
               pc_plus4, imm, jidx, pred_taken,
        input  out_valid, is_ctrl, taken, target, redirect, redirect_pc,
               cnt_ctrl, cnt_taken, cnt_mispred
    );

    modport slave (
        input  in_valid, stall, flush, cnt_clr, opcode, rt, rd1, rd2,
               pc_plus4, imm, jidx, pred_taken,
        output out_valid, is_ctrl, taken, target, redirect, redirect_pc,
               cnt_ctrl, cnt_taken, cnt_mispred
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Registered MIPS branch/jump resolution: decodes the control op, resolves the
// outcome and target, flags mispredicts and keeps saturating event counters.
module branch_resolve_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input logic             clk,
    input logic             rst_n,
    branch_resolve_unit_if.slave bus
);
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [4:0] RT_BLTZ   = 5'b00000;
    localparam logic [4:0] RT_BGEZ   = 5'b00001;

    logic             is_ctrl_c;
    logic             taken_c;
    logic             is_jump_c;
    logic             rd1_neg_c;
    logic             rd1_zero_c;
    logic [WIDTH-1:0] br_target_c;
    logic [WIDTH-1:0] j_target_c;
    logic [WIDTH-1:0] target_c;
    logic [WIDTH-1:0] redirect_pc_c;
    logic             mispred_c;
    logic             capture_c;

    // Signed compares against zero reduce to sign bit and zero detect.
    assign rd1_neg_c  = bus.rd1[WIDTH-1];
    assign rd1_zero_c = (bus.rd1 == '0);

    assign br_target_c = bus.pc_plus4 + {{(WIDTH-18){bus.imm[15]}}, bus.imm, 2'b00};
    assign j_target_c  = {bus.pc_plus4[WIDTH-1:28], bus.jidx, 2'b00};

    // Decode and taken condition.
    always_comb begin
        is_ctrl_c = 1'b0;
        taken_c   = 1'b0;
        is_jump_c = 1'b0;
        case (bus.opcode)
            OP_BEQ: begin
                is_ctrl_c = 1'b1;
                taken_c   = (bus.rd1 == bus.rd2);
            end
            OP_BNE: begin
                is_ctrl_c = 1'b1;
                taken_c   = (bus.rd1 != bus.rd2);
            end
            OP_BLEZ: begin
                is_ctrl_c = 1'b1;
                taken_c   = rd1_neg_c | rd1_zero_c;
            end
            OP_BGTZ: begin
                is_ctrl_c = 1'b1;
                taken_c   = ~rd1_neg_c & ~rd1_zero_c;
            end
            OP_REGIMM: begin
                if (bus.rt == RT_BLTZ) begin
                    is_ctrl_c = 1'b1;
                    taken_c   = rd1_neg_c;
                end else if (bus.rt == RT_BGEZ) begin
                    is_ctrl_c = 1'b1;
                    taken_c   = ~rd1_neg_c;
                end
            end
            OP_J, OP_JAL: begin
                is_ctrl_c = 1'b1;
                taken_c   = 1'b1;
                is_jump_c = 1'b1;
            end
            default: ;
        endcase
    end

    assign target_c      = !is_ctrl_c ? '0 : (is_jump_c ? j_target_c : br_target_c);
    assign redirect_pc_c = taken_c ? target_c : bus.pc_plus4;
    assign mispred_c     = taken_c ^ bus.pred_taken;
    assign capture_c     = bus.in_valid & ~bus.stall & ~bus.flush;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic en);
        if (en && (cnt != '1)) return cnt + CNT_W'(1);
        return cnt;
    endfunction

    // Result register: flush beats stall beats capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid   <= 1'b0;
            bus.is_ctrl     <= 1'b0;
            bus.taken       <= 1'b0;
            bus.target      <= '0;
            bus.redirect    <= 1'b0;
            bus.redirect_pc <= '0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
            bus.redirect  <= 1'b0;
        end else if (!bus.stall) begin
            if (bus.in_valid) begin
                bus.out_valid   <= 1'b1;
                bus.is_ctrl     <= is_ctrl_c;
                bus.taken       <= taken_c;
                bus.target      <= target_c;
                bus.redirect    <= mispred_c;
                bus.redirect_pc <= redirect_pc_c;
            end else begin
                bus.out_valid <= 1'b0;
                bus.redirect  <= 1'b0;
            end
        end
    end

    // Event counters; clear wins over a simultaneous capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.cnt_ctrl    <= '0;
            bus.cnt_taken   <= '0;
            bus.cnt_mispred <= '0;
        end else if (bus.cnt_clr) begin
            bus.cnt_ctrl    <= '0;
            bus.cnt_taken   <= '0;
            bus.cnt_mispred <= '0;
        end else if (capture_c) begin
            bus.cnt_ctrl    <= sat_inc(bus.cnt_ctrl, is_ctrl_c);
            bus.cnt_taken   <= sat_inc(bus.cnt_taken, taken_c);
            bus.cnt_mispred <= sat_inc(bus.cnt_mispred, mispred_c);
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit (WIDTH=32, CNT_W=2 so saturation is reachable).
module tb_branch_resolve_unit;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   passes = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    branch_resolve_unit_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    branch_resolve_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ov, input logic ic, input logic tk,
                           input logic [31:0] tgt, input logic rd, input logic [31:0] rpc);
        chk({tag, ".out_valid"},   32'(bus.out_valid),   32'(ov));
        chk({tag, ".is_ctrl"},     32'(bus.is_ctrl),     32'(ic));
        chk({tag, ".taken"},       32'(bus.taken),       32'(tk));
        chk({tag, ".target"},      bus.target,           tgt);
        chk({tag, ".redirect"},    32'(bus.redirect),    32'(rd));
        chk({tag, ".redirect_pc"}, bus.redirect_pc,      rpc);
    endtask

    task automatic chk_cnt(input string tag, input int c, input int t, input int m);
        chk({tag, ".cnt_ctrl"},    32'(bus.cnt_ctrl),    32'(c));
        chk({tag, ".cnt_taken"},   32'(bus.cnt_taken),   32'(t));
        chk({tag, ".cnt_mispred"}, 32'(bus.cnt_mispred), 32'(m));
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rt,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc4,
                         input logic [15:0] imm, input logic [25:0] jidx, input logic pred);
        bus.in_valid   = v;
        bus.opcode     = op;
        bus.rt         = rt;
        bus.rd1        = a;
        bus.rd2        = b;
        bus.pc_plus4   = pc4;
        bus.imm        = imm;
        bus.jidx       = jidx;
        bus.pred_taken = pred;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.stall   = 1'b0;
        bus.flush   = 1'b0;
        bus.cnt_clr = 1'b0;
        drive(1'b0, 6'd0, 5'd0, 0, 0, 0, 16'd0, 26'd0, 1'b0);
        #1;
        chk_out("reset", 0, 0, 0, 32'h0, 0, 32'h0);
        chk_cnt("reset", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // beq taken, predicted not taken
        drive(1'b1, 6'b000100, 5'd0, 32'd5, 32'd5, 32'h100, 16'hFFFF, 26'd0, 1'b0);
        step();
        chk_out("beq_mis", 1, 1, 1, 32'hFC, 1, 32'hFC);
        chk_cnt("beq_mis", 1, 1, 1);

        bus.cnt_clr = 1'b1;
        drive(1'b0, 6'd0, 5'd0, 0, 0, 0, 16'd0, 26'd0, 1'b0);
        step();
        bus.cnt_clr = 1'b0;
        chk("idle.out_valid", 32'(bus.out_valid), 32'd0);
        chk("idle.redirect", 32'(bus.redirect), 32'd0);
        chk_cnt("clr", 0, 0, 0);

        // Signed compares
        drive(1'b1, 6'b000110, 5'd0, 32'h8000_0000, 32'd0, 32'h200, 16'h0004, 26'd0, 1'b1);
        step();
        chk_out("blez_neg", 1, 1, 1, 32'h210, 0, 32'h210);
        drive(1'b1, 6'b000111, 5'd0, 32'd0, 32'd0, 32'h300, 16'h0010, 26'd0, 1'b1);
        step();
        chk_out("bgtz_zero", 1, 1, 0, 32'h340, 1, 32'h300);
        drive(1'b1, 6'b000001, 5'd1, 32'd0, 32'd0, 32'h400, 16'h0001, 26'd0, 1'b0);
        step();
        chk_out("bgez_zero", 1, 1, 1, 32'h404, 1, 32'h404);
        drive(1'b1, 6'b000001, 5'd2, 32'd0, 32'd0, 32'h500, 16'h0001, 26'd0, 1'b1);
        step();
        chk_out("regimm_rt2", 1, 0, 0, 32'h0, 1, 32'h500);
        chk_cnt("signed", 3, 2, 3);

        bus.cnt_clr = 1'b1;
        drive(1'b0, 6'd0, 5'd0, 0, 0, 0, 16'd0, 26'd0, 1'b0);
        step();
        bus.cnt_clr = 1'b0;

        // Five taken control ops saturate cnt_taken at 3
        drive(1'b1, 6'b000010, 5'd0, 0, 0, 32'hF000_0000, 16'd0, 26'h3FF_FFFF, 1'b1);
        step();
        chk_out("j_top", 1, 1, 1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC);
        drive(1'b1, 6'b000100, 5'd0, 32'd7, 32'd7, 32'hFFFF_FFFC, 16'h0001, 26'd0, 1'b1);
        step();
        chk_out("beq_wrap", 1, 1, 1, 32'h0, 0, 32'h0);
        drive(1'b1, 6'b000101, 5'd0, 32'd1, 32'd2, 32'h400, 16'hFFFE, 26'd0, 1'b0);
        step();
        chk_out("bne", 1, 1, 1, 32'h3F8, 1, 32'h3F8);
        drive(1'b1, 6'b000001, 5'd0, 32'hFFFF_FFFF, 32'd0, 32'h800, 16'h0003, 26'd0, 1'b0);
        step();
        chk_out("bltz", 1, 1, 1, 32'h80C, 1, 32'h80C);
        drive(1'b1, 6'b000011, 5'd0, 0, 0, 32'h1234_5678, 16'd0, 26'h000_0010, 1'b0);
        step();
        chk_out("jal", 1, 1, 1, 32'h1000_0040, 1, 32'h1000_0040);
        chk_cnt("sat", 3, 3, 3);

        bus.cnt_clr = 1'b1;
        drive(1'b0, 6'd0, 5'd0, 0, 0, 0, 16'd0, 26'd0, 1'b0);
        step();
        bus.cnt_clr = 1'b0;

        // Stall holds a redirecting result for three cycles
        drive(1'b1, 6'b000100, 5'd0, 32'd3, 32'd3, 32'h500, 16'h0002, 26'd0, 1'b0);
        step();
        chk_out("pre_stall", 1, 1, 1, 32'h508, 1, 32'h508);
        bus.stall = 1'b1;
        drive(1'b1, 6'b000101, 5'd0, 32'd4, 32'd4, 32'h600, 16'h0001, 26'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out($sformatf("stall%0d", i), 1, 1, 1, 32'h508, 1, 32'h508);
            chk_cnt($sformatf("stall%0d", i), 1, 1, 1);
        end

        // Flush wins over stall
        bus.flush = 1'b1;
        step();
        chk("flush.out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush.redirect", 32'(bus.redirect), 32'd0);
        chk_cnt("flush", 1, 1, 1);
        bus.stall = 1'b0;
        bus.flush = 1'b0;

        // cnt_clr beats a simultaneous capture
        bus.cnt_clr = 1'b1;
        drive(1'b1, 6'b000100, 5'd0, 32'd9, 32'd9, 32'h700, 16'h0001, 26'd0, 1'b0);
        step();
        bus.cnt_clr = 1'b0;
        chk_out("clr_cap", 1, 1, 1, 32'h704, 1, 32'h704);
        chk_cnt("clr_cap", 0, 0, 0);

        // Mid-stream reset drops the in-flight result
        drive(1'b1, 6'b000010, 5'd0, 0, 0, 32'h0000_1000, 16'd0, 26'h000_0100, 1'b0);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("mid_rst", 0, 0, 0, 32'h0, 0, 32'h0);
        chk_cnt("mid_rst", 0, 0, 0);
        drive(1'b0, 6'd0, 5'd0, 0, 0, 0, 16'd0, 26'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_idle.out_valid", 32'(bus.out_valid), 32'd0);
        drive(1'b1, 6'b000111, 5'd0, 32'd5, 32'd0, 32'h700, 16'h0001, 26'd0, 1'b0);
        step();
        chk_out("post_rst", 1, 1, 1, 32'h704, 1, 32'h704);
        chk_cnt("post_rst", 1, 1, 1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised, registered branch/jump resolution stage for the MIPS pipeline. It evaluates all supported conditional branches (beq, bne, blez, bgtz, bltz, bgez) and the jumps j and jal. It computes the branch or jump target and compares the outcome with the front-end prediction. Each resolved instruction leaves one cycle later with a redirect request, and the unit keeps saturating event counters.

## Interface
- WIDTH, 32: data and PC width; must be ≥ 32.
- CNT_W, 16: width of each event counter.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input instruction valid.
- stall  in  1  hold the output register; do not sample inputs.
- flush  in  1  discard the input and invalidate the output; priority over stall.
- cnt_clr  in  1  synchronous clear of all counters.
- opcode  in  6  instruction [31:26].
- rt  in  5  instruction [20:16]; selects REGIMM sub-op.
- rd1, rd2  in  WIDTH  register operands rs, rt.
- pc_plus4  in  WIDTH  PC of instruction + 4.
- imm  in  16  branch offset, in words.
- jidx  in  26  jump index.
- pred_taken  in  1  front-end prediction.
- out_valid  out  1  registered result valid.
- is_ctrl  out  1  instruction was a supported branch or jump.
- taken  out  1  resolved outcome.
- target  out  WIDTH  computed target; 0 for non-control instructions.
- redirect  out  1  mispredict; fetch must restart at redirect_pc.
- redirect_pc  out  WIDTH  taken ? target : pc_plus4.
- cnt_ctrl, cnt_taken, cnt_mispred  out  CNT_W  saturating event counters.

## Operation
- Decode and taken condition (all comparisons signed, two's complement, full WIDTH):
  - 000100 beq: rd1 == rd2.
  - 000101 bne: rd1 != rd2.
  - 000110 blez: rd1 ≤ 0.
  - 000111 bgtz: rd1 > 0.
  - 000001 with rt=00000 bltz: rd1 < 0.
  - 000001 with rt=00001 bgez: rd1 ≥ 0.
  - 000010 j and 000011 jal: always taken.
- Any other opcode, or 000001 with any other rt value: is_ctrl=0, taken=0, target=0.
- Branch target = pc_plus4 + (sign_extend(imm) << 2), truncated to WIDTH, wrapping modulo 2^WIDTH.
- Jump target = {pc_plus4[WIDTH-1:28], jidx, 2'b00}.
- Mispredict = (taken != pred_taken). This includes pred_taken=1 on a non-control instruction, which gives redirect=1 with redirect_pc=pc_plus4.
- Register update priority, highest first:
  1. flush: out_valid←0 and redirect←0; other outputs may hold.
  2. stall: all output registers hold.
  3. in_valid: capture the new result; out_valid←1.
  4. Otherwise: out_valid←0 and redirect←0.
- redirect is asserted only together with out_valid=1.
- Counters update on the same edge as a capture under rule 3:
  - cnt_ctrl += is_ctrl.
  - cnt_taken += taken.
  - cnt_mispred += mispredict.
  - Each counter saturates at 2^CNT_W−1 and never wraps.
  - When flush or stall wins, counters do not change.
- cnt_clr zeroes all counters on the next edge. If cnt_clr and a capture occur on the same edge, cnt_clr wins and the counters read 0.

## Timing
- Latency: 1 cycle from input sampling to output; throughput 1 per cycle.
- Reset (rst_n=0, takes effect immediately): every output and every counter is 0, including out_valid, redirect, redirect_pc and target.
- Reset asserted mid-operation drops the in-flight result; nothing is reported after release.
- Release of rst_n is synchronised externally; the first capture happens on the first edge with rst_n=1.
- stall held for N cycles keeps the outputs, including redirect, stable for N cycles.

## Test plan
- Reset: assert rst_n=0 mid-stream -> all outputs and counters read 0 immediately; first post-release capture is correct.
- beq taken, mispredicted: rd1=rd2=5, imm=0xFFFF, pc_plus4=0x100, pred=0 -> next cycle taken=1, target=0xFC, redirect=1, redirect_pc=0xFC, cnt_mispred=1.
- Signed compare: blez with rd1=0x80000000 -> taken; bgtz with rd1=0 -> not taken; bgez (rt=1) with rd1=0 -> taken; opcode 000001 with rt=2 -> is_ctrl=0.
- Jump and wrap: j with pc_plus4=0xF0000000, jidx=0x3FFFFFF -> target=0xFFFFFFFC. beq with pc_plus4=0xFFFFFFFC, imm=1 (taken) -> target=0x00000000.
- Flush vs stall: stall=1 and flush=1 on the same edge -> out_valid=0 next cycle, counters unchanged. stall alone for 3 cycles -> outputs held for 3 cycles.
- Saturation and clear: CNT_W=2; 5 taken branches -> cnt_taken=3. cnt_clr on the same edge as a capture -> all counters 0.
